// File: rtl/uart_boot_host_if.sv
// Signal bundle between the boot sequencer, its source memories, UART_TX/UART_RX and the controller.
interface uart_boot_host_if #(
    parameter int AW = 16
) ();
    logic          i_start;
    logic [31:0]   i_prog_len;
    logic [AW-1:0] i_stdin_len;
    logic          o_mem_sel;
    logic [AW-1:0] o_mem_addr;
    logic [7:0]    i_mem_rdata;
    logic [7:0]    o_tx_data;
    logic          o_tx_start;
    logic          i_tx_busy;
    logic [7:0]    i_rx_data;
    logic          i_rx_valid;
    logic          i_rx_ferr;
    logic          o_res_we;
    logic [AW-1:0] o_res_addr;
    logic [7:0]    o_res_wdata;
    logic [AW:0]   o_res_count;
    logic          o_overflow;
    logic          o_ferr_seen;
    logic          o_busy;
    logic          o_done;

    modport slave (
        input  i_start, i_prog_len, i_stdin_len, i_mem_rdata, i_tx_busy,
               i_rx_data, i_rx_valid, i_rx_ferr,
        output o_mem_sel, o_mem_addr, o_tx_data, o_tx_start, o_res_we, o_res_addr,
               o_res_wdata, o_res_count, o_overflow, o_ferr_seen, o_busy, o_done
    );

    modport master (
        output i_start, i_prog_len, i_stdin_len, i_mem_rdata, i_tx_busy,
               i_rx_data, i_rx_valid, i_rx_ferr,
        input  o_mem_sel, o_mem_addr, o_tx_data, o_tx_start, o_res_we, o_res_addr,
               o_res_wdata, o_res_count, o_overflow, o_ferr_seen, o_busy, o_done
    );
endinterface

// File: rtl/uart_boot_host.sv
// Host-side boot sequencer for the CPU UART loader: waits for sync bytes, streams length,
// program and stdin bytes to UART_TX, and captures CPU output into a bounded result buffer.
module uart_boot_host #(
    parameter int          AW           = 16,
    parameter int          RESULT_DEPTH = 128,
    parameter logic [7:0]  SYNC_PROG    = 8'h99,
    parameter logic [7:0]  SYNC_STDIN   = 8'hAA,
    parameter int unsigned IDLE_TIMEOUT = 100000
) (
    input logic             clk,
    input logic             reset_n,
    uart_boot_host_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_SP, S_SEND_LEN, S_SEND_PROG,
        S_WAIT_SS, S_SEND_STDIN, S_COLLECT, S_DONE
    } state_t;

    typedef enum logic [1:0] { P_ADDR, P_LOAD, P_SEND } phase_t;

    localparam logic [AW:0] RES_FULL = (AW+1)'(RESULT_DEPTH);

    state_t        r_state;
    phase_t        r_phase;
    logic [31:0]   r_idx;
    logic [31:0]   r_len;
    logic [31:0]   r_progLen;
    logic [AW-1:0] r_stdinLen;
    logic          r_memSel;
    logic [7:0]    r_txData;
    logic          r_txStart;
    logic          r_guard;
    logic [AW:0]   r_resCount;
    logic          r_overflow;
    logic          r_ferrSeen;
    logic          r_busy;
    logic          r_done;
    logic [31:0]   r_idle;

    logic       w_sending;
    logic       w_capState;
    logic       w_rxGood;
    logic       w_full;
    logic       w_resWe;
    logic       w_txFire;
    logic       w_lastByte;
    logic [7:0] w_lenByte;

    assign w_sending  = (r_state == S_SEND_LEN) || (r_state == S_SEND_PROG) || (r_state == S_SEND_STDIN);
    assign w_capState = (r_state == S_SEND_STDIN) || (r_state == S_COLLECT);
    assign w_rxGood   = bus.i_rx_valid & ~bus.i_rx_ferr;
    assign w_full     = (r_resCount == RES_FULL);
    assign w_resWe    = w_capState & w_rxGood & ~w_full;
    assign w_txFire   = w_sending && (r_phase == P_SEND) && !bus.i_tx_busy && !r_guard;
    assign w_lastByte = (r_idx == r_len - 32'd1);

    always_comb begin
        w_lenByte = r_progLen[7:0];
        case (r_idx[1:0])
            2'd1:    w_lenByte = r_progLen[15:8];
            2'd2:    w_lenByte = r_progLen[23:16];
            2'd3:    w_lenByte = r_progLen[31:24];
            default: w_lenByte = r_progLen[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_phase    <= P_ADDR;
            r_idx      <= '0;
            r_len      <= '0;
            r_progLen  <= '0;
            r_stdinLen <= '0;
            r_memSel   <= 1'b0;
            r_txData   <= '0;
            r_txStart  <= 1'b0;
            r_guard    <= 1'b0;
            r_resCount <= '0;
            r_overflow <= 1'b0;
            r_ferrSeen <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_idle     <= '0;
        end else begin
            r_txStart <= 1'b0;

            // Guard stays up through the pulse and one cycle after, so UART_TX busy latency is covered.
            if (w_txFire)
                r_guard <= 1'b1;
            else if (!r_txStart)
                r_guard <= 1'b0;

            if (w_capState && bus.i_rx_valid) begin
                if (bus.i_rx_ferr)
                    r_ferrSeen <= 1'b1;
                else if (w_full)
                    r_overflow <= 1'b1;
                else
                    r_resCount <= r_resCount + 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.i_start) begin
                        r_progLen  <= bus.i_prog_len;
                        r_stdinLen <= bus.i_stdin_len;
                        r_resCount <= '0;
                        r_overflow <= 1'b0;
                        r_ferrSeen <= 1'b0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_state    <= S_WAIT_SP;
                    end
                end
                S_WAIT_SP: begin
                    if (w_rxGood && bus.i_rx_data == SYNC_PROG) begin
                        r_state <= S_SEND_LEN;
                        r_idx   <= '0;
                        r_len   <= 32'd4;
                        r_phase <= P_ADDR;
                    end
                end
                S_SEND_LEN, S_SEND_PROG, S_SEND_STDIN: begin
                    case (r_phase)
                        P_ADDR: r_phase <= P_LOAD;
                        P_LOAD: begin
                            r_txData <= (r_state == S_SEND_LEN) ? w_lenByte : bus.i_mem_rdata;
                            r_phase  <= P_SEND;
                        end
                        default: begin
                            if (w_txFire) begin
                                r_txStart <= 1'b1;
                                r_phase   <= P_ADDR;
                                if (!w_lastByte) begin
                                    r_idx <= r_idx + 32'd1;
                                end else begin
                                    r_idx <= '0;
                                    if (r_state == S_SEND_LEN && r_progLen != 32'd0) begin
                                        r_state  <= S_SEND_PROG;
                                        r_len    <= r_progLen;
                                        r_memSel <= 1'b0;
                                    end else if (r_state == S_SEND_STDIN) begin
                                        r_state <= S_COLLECT;
                                        r_idle  <= '0;
                                    end else begin
                                        r_state <= S_WAIT_SS;
                                    end
                                end
                            end
                        end
                    endcase
                end
                S_WAIT_SS: begin
                    if (w_rxGood && bus.i_rx_data == SYNC_STDIN) begin
                        r_idx   <= '0;
                        r_phase <= P_ADDR;
                        if (r_stdinLen == '0) begin
                            r_state <= S_COLLECT;
                            r_idle  <= '0;
                        end else begin
                            r_state  <= S_SEND_STDIN;
                            r_len    <= 32'(r_stdinLen);
                            r_memSel <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    // r_idle counts edges since the last rx byte; a zero timeout never ends collection.
                    if (bus.i_rx_valid) begin
                        r_idle <= '0;
                    end else if (IDLE_TIMEOUT != 0 && r_idle + 32'd1 == IDLE_TIMEOUT) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_mem_sel   = r_memSel;
    assign bus.o_mem_addr  = r_idx[AW-1:0];
    assign bus.o_tx_data   = r_txData;
    assign bus.o_tx_start  = r_txStart;
    assign bus.o_res_we    = w_resWe;
    assign bus.o_res_addr  = r_resCount[AW-1:0];
    assign bus.o_res_wdata = bus.i_rx_data;
    assign bus.o_res_count = r_resCount;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_ferr_seen = r_ferrSeen;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;

endmodule

// File: tb/tb_uart_boot_host.sv
// Randomized bench for uart_boot_host: memory, UART_TX and result-buffer models plus a byte-level reference.
module tb_uart_boot_host;

    localparam int AW      = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 50;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_boot_host_if #(.AW(AW)) bus ();

    uart_boot_host #(
        .AW(AW), .RESULT_DEPTH(DEPTH), .SYNC_PROG(8'h99),
        .SYNC_STDIN(8'hAA), .IDLE_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] progMem  [256];
    logic [7:0] stdinMem [256];
    logic [7:0] resBuf   [256];
    logic [7:0] txQ [$];
    int busyLeft = 0;
    int protoErrors = 0;
    int resWrites = 0;
    int badWrites = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Source memory with one cycle of read latency.
    always @(posedge clk)
        bus.i_mem_rdata <= bus.o_mem_sel ? stdinMem[bus.o_mem_addr] : progMem[bus.o_mem_addr];

    // UART_TX: each accepted byte keeps busy high for a random number of cycles.
    always @(negedge clk) begin
        if (bus.o_tx_start) begin
            if (busyLeft > 0) protoErrors++;
            txQ.push_back(bus.o_tx_data);
            busyLeft = $urandom_range(2, 6);
        end else if (busyLeft > 0) begin
            busyLeft--;
        end
        bus.i_tx_busy = (busyLeft > 0);
    end

    always @(negedge clk) begin
        if (bus.o_res_we) begin
            resBuf[bus.o_res_addr] = bus.o_res_wdata;
            resWrites++;
            if (bus.i_rx_ferr || !bus.i_rx_valid) badWrites++;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input logic ferr);
        @(posedge clk); #1;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_ferr  = ferr;
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_ferr  = 1'b0;
    endtask

    task automatic pulseStart(input int pl, input int sl);
        @(posedge clk); #1;
        bus.i_prog_len  = 32'(pl);
        bus.i_stdin_len = AW'(sl);
        bus.i_start     = 1'b1;
        @(posedge clk); #1;
        bus.i_start     = 1'b0;
    endtask

    task automatic waitTx(input int n, input string tag);
        int cyc = 0;
        while (txQ.size() < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput(tag, 64'(txQ.size()), 64'(n));
    endtask

    // ferrMode: 0 none, 1 first stdin-phase rx byte has a framing error, 2 random framing errors.
    task automatic runOne(input int pl, input int sl, input int nStdinRx, input int nCollect,
                          input int ferrMode, input bit fixedProg);
        logic [7:0] expTx [$];
        logic [7:0] expRes [$];
        logic [7:0] b;
        logic f;
        logic [31:0] plWord;
        int nValid = 0;
        bit expFerr = 0;
        int k;

        for (int i = 0; i < 256; i++) begin
            progMem[i]  = 8'($urandom);
            stdinMem[i] = 8'($urandom);
            resBuf[i]   = 8'h00;
        end
        if (fixedProg)
            for (int i = 0; i < pl; i++) progMem[i] = 8'(8'h11 + i);
        txQ.delete();
        resWrites = 0;

        plWord = 32'(pl);
        for (int i = 0; i < 4; i++) expTx.push_back(8'(plWord >> (8 * i)));
        for (int i = 0; i < pl; i++) expTx.push_back(progMem[i]);
        for (int i = 0; i < sl; i++) expTx.push_back(stdinMem[i]);

        pulseStart(pl, sl);
        checkOutput("start_clears_count", 64'(bus.o_res_count), 64'd0);
        checkOutput("start_clears_ovf", 64'(bus.o_overflow), 64'd0);
        checkOutput("busy_after_start", 64'(bus.o_busy), 64'd1);

        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'h99, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("no_tx_before_sync", 64'(txQ.size()), 64'd0);
        checkOutput("wait_sp_no_capture", 64'(bus.o_res_count), 64'd0);

        applyStimulus(8'h99, 1'b0);
        waitTx(4 + pl, "tx_prog_count");
        repeat (15) @(posedge clk);
        #1;
        checkOutput("no_tx_before_ss", 64'(txQ.size()), 64'(4 + pl));

        pulseStart(7, 2);
        checkOutput("start_ignored_busy", 64'(bus.o_busy), 64'd1);
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'hAA, 1'b0);

        if (sl > 0) begin
            waitTx(5 + pl, "stdin_first_tx");
            for (int i = 0; i < nStdinRx; i++) begin
                b = 8'($urandom);
                f = (ferrMode == 1 && i == 0) || (ferrMode == 2 && $urandom_range(0, 3) == 0);
                applyStimulus(b, f);
                if (f) expFerr = 1;
                else begin
                    if (expRes.size() < DEPTH) expRes.push_back(b);
                    nValid++;
                end
            end
        end
        waitTx(4 + pl + sl, "tx_total_count");

        for (int i = 0; i < nCollect; i++) begin
            repeat ($urandom_range(0, 10)) @(posedge clk);
            b = 8'($urandom);
            f = (ferrMode == 2 && $urandom_range(0, 3) == 0);
            applyStimulus(b, f);
            if (f) expFerr = 1;
            else begin
                if (expRes.size() < DEPTH) expRes.push_back(b);
                nValid++;
            end
        end

        // done is registered TIMEOUT edges after the edge that sampled the last rx byte
        k = 0;
        while (k < 3 * TIMEOUT && !bus.o_done) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("done_latency", 64'(k), 64'(TIMEOUT));

        checkOutput("tx_final_count", 64'(txQ.size()), 64'(expTx.size()));
        for (int i = 0; i < expTx.size() && i < txQ.size(); i++)
            checkOutput($sformatf("tx_byte%0d", i), 64'(txQ[i]), 64'(expTx[i]));
        checkOutput("res_count", 64'(bus.o_res_count), 64'(expRes.size()));
        checkOutput("res_writes", 64'(resWrites), 64'(expRes.size()));
        checkOutput("overflow", 64'(bus.o_overflow), 64'(nValid > DEPTH));
        checkOutput("ferr_seen", 64'(bus.o_ferr_seen), 64'(expFerr));
        for (int i = 0; i < expRes.size(); i++)
            checkOutput($sformatf("res_byte%0d", i), 64'(resBuf[i]), 64'(expRes[i]));
        checkOutput("busy_in_done", 64'(bus.o_busy), 64'd0);
        checkOutput("bad_writes", 64'(badWrites), 64'd0);
        checkOutput("tx_protocol", 64'(protoErrors), 64'd0);
    endtask

    task automatic runResetMidProg();
        int n;
        for (int i = 0; i < 256; i++) progMem[i] = 8'($urandom);
        txQ.delete();
        pulseStart(20, 3);
        applyStimulus(8'h99, 1'b0);
        waitTx(6, "reset_prog_progress");
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_tx_start", 64'(bus.o_tx_start), 64'd0);
        checkOutput("rst_busy", 64'(bus.o_busy), 64'd0);
        checkOutput("rst_done", 64'(bus.o_done), 64'd0);
        n = txQ.size();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("no_tx_after_reset", 64'(txQ.size()), 64'(n));
        checkOutput("idle_after_reset", 64'(bus.o_busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.i_start     = 1'b0;
        bus.i_prog_len  = '0;
        bus.i_stdin_len = '0;
        bus.i_rx_data   = '0;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_ferr   = 1'b0;
        bus.i_tx_busy   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(bus.o_busy), 64'd0);
        checkOutput("reset_done", 64'(bus.o_done), 64'd0);
        checkOutput("reset_tx_start", 64'(bus.o_tx_start), 64'd0);
        checkOutput("reset_res_count", 64'(bus.o_res_count), 64'd0);
        checkOutput("reset_flags", 64'({bus.o_overflow, bus.o_ferr_seen, bus.o_res_we}), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        runOne(5, 3, 2, 6, 1, 1'b1);
        runOne(0, 0, 0, 3, 0, 1'b0);
        runResetMidProg();
        for (int r = 0; r < 5; r++)
            runOne($urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 3),
                   $urandom_range(1, 7), 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
